// File: rtl/pipe_chain_if.sv
// Bundled entry, control, stage-view and counter signals for pipe_chain.
// The slave modport faces the pipeline; the master modport faces whatever drives it.
interface pipe_chain_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_halt;
  logic                   in_ready;
  logic                   stall;
  logic                   flush;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   hlt;
  logic [15:0]            stall_cnt;
  logic [15:0]            flush_cnt;
  logic [15:0]            retire_cnt;

  modport master (
    output in_valid, in_data, in_halt, stall, flush,
    input  in_ready, stage_valid, stage_data, out_valid, out_data, hlt,
           stall_cnt, flush_cnt, retire_cnt
  );

  modport slave (
    input  in_valid, in_data, in_halt, stall, flush,
    output in_ready, stage_valid, stage_data, out_valid, out_data, hlt,
           stall_cnt, flush_cnt, retire_cnt
  );
endinterface

// File: rtl/pipe_chain.sv
// Linear in-order pipeline with partial stall, partial flush and a sticky halt.
// Define PIPE_CHAIN_PERF_EN to build the saturating stall/flush/retire counters.
module pipe_chain #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 4,
  parameter int STALL_STAGE  = 1,
  parameter int FLUSH_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_chain_if.slave  bus
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] halt_q, halt_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic             hlt_q, hlt_d;

  logic [DEPTH-1:0] src_valid;
  logic [DEPTH-1:0] src_halt;
  logic [WIDTH-1:0] src_data [DEPTH];

  logic             halt_in_flight;
  logic             in_ready;
  logic             accept;
  logic             stall_eff;
  logic [DEPTH*WIDTH-1:0] stage_data_flat;

  // A halt anywhere in the pipe or already retired closes the entry.
  always_comb begin
    halt_in_flight = |(valid_q & halt_q);
    in_ready       = ~bus.stall & ~bus.flush & ~hlt_q & ~halt_in_flight;
    accept         = bus.in_valid & in_ready;
    stall_eff      = bus.stall & ~bus.flush;
  end

  // Squashed stages must not feed their successor, so the flush also bubbles stage FLUSH_STAGES.
  always_comb begin
    src_valid = '0;
    src_halt  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      src_data[k] = '0;
    end
    src_valid[0] = accept;
    src_halt[0]  = bus.in_halt;
    src_data[0]  = bus.in_data;
    for (int k = 1; k < DEPTH; k++) begin
      src_valid[k] = valid_q[k-1] & ~(bus.flush & ((k - 1) < FLUSH_STAGES));
      src_halt[k]  = halt_q[k-1];
      src_data[k]  = data_q[k-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    halt_d  = halt_q;
    for (int k = 0; k < DEPTH; k++) begin
      data_d[k] = data_q[k];
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (bus.flush && (k < FLUSH_STAGES)) begin
        valid_d[k] = 1'b0;
        halt_d[k]  = 1'b0;
      end else if (stall_eff && (k <= STALL_STAGE)) begin
        valid_d[k] = valid_q[k];
        halt_d[k]  = halt_q[k];
      end else if (stall_eff && (k == STALL_STAGE + 1)) begin
        valid_d[k] = 1'b0;
        halt_d[k]  = 1'b0;
      end else begin
        valid_d[k] = src_valid[k];
        halt_d[k]  = src_valid[k] & src_halt[k];
        // Payload only moves with a valid entry; bubbles leave the old data in place.
        if (src_valid[k]) begin
          data_d[k] = src_data[k];
        end
      end
    end
    hlt_d = hlt_q | (valid_q[DEPTH-1] & halt_q[DEPTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      halt_q  <= '0;
      hlt_q   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      halt_q  <= halt_d;
      hlt_q   <= hlt_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  always_comb begin
    stage_data_flat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stage_data_flat[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.stage_valid = valid_q;
  assign bus.stage_data  = stage_data_flat;
  assign bus.out_valid   = valid_q[DEPTH-1];
  assign bus.out_data    = data_q[DEPTH-1];
  assign bus.hlt         = hlt_q;

`ifdef PIPE_CHAIN_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (stall_eff && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (bus.flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
    if (valid_q[DEPTH-1] && (retire_cnt_q != 16'hFFFF)) begin
      retire_cnt_d = retire_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
  assign bus.retire_cnt = retire_cnt_q;
`else
  assign bus.stall_cnt  = '0;
  assign bus.flush_cnt  = '0;
  assign bus.retire_cnt = '0;
`endif

endmodule
